reorder_buffer: RTL and testbench

Circular reorder buffer between the rename stage and architectural commit. It allocates the ROB entry for each renamed instruction (destROB to the register status table) and collects execution results on the writeback bus. It retires results strictly in program order, driving validCommit/commitROB/regCommit back to the register status table and the register file. It also raises a one-cycle flush when a mispredicted branch reaches the head.

---
 rtl/reorder_buffer.sv | 129 ++++++++++++
 tb/tb_reorder_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: 8-entry circular reorder buffer between rename and commit.
//
// Entries are allocated in program order at the tail and filled out of order
// by the writeback bus. They retire one per cycle, in order, from the head.
// A mispredicted branch that retires raises a one-cycle flush. That flush
// empties the buffer once the branch itself has committed.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   alloc, allocDest, allocRegWrite, allocBranch
//                       rename-stage allocation request and its attributes
//   destROB, full       entry granted to alloc (tail); no free entry
//   wbValid, wbROB, wbResult, wbMispredict
//                       writeback bus
//   validCommit, commitROB, regCommit, commitRegWrite, commitResult
//                       retiring head entry (data gated to 0 when not retiring)
//   flush               retiring entry was a mispredicted branch
module reorder_buffer #(
  parameter int ROB   = 2,
  parameter int REG   = 4,
  parameter int WIDTH = 31
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           alloc,
  input  logic [REG:0]   allocDest,
  input  logic           allocRegWrite,
  input  logic           allocBranch,
  output logic [ROB:0]   destROB,
  output logic           full,
  input  logic           wbValid,
  input  logic [ROB:0]   wbROB,
  input  logic [WIDTH:0] wbResult,
  input  logic           wbMispredict,
  output logic           validCommit,
  output logic [ROB:0]   commitROB,
  output logic [REG:0]   regCommit,
  output logic           commitRegWrite,
  output logic [WIDTH:0] commitResult,
  output logic           flush
);

  localparam int N = 2 ** (ROB + 1);
  localparam logic [ROB+1:0] N_CNT = (ROB + 2)'(N);

  logic [N-1:0]   valid;
  logic [N-1:0]   ready;
  logic [N-1:0]   reg_write;
  logic [N-1:0]   branch;
  logic [N-1:0]   mispredict;
  logic [REG:0]   dest   [N];
  logic [WIDTH:0] result [N];

  logic [ROB:0]   head;
  logic [ROB:0]   tail;
  logic [ROB+1:0] count;

  logic full_int;
  logic head_commit;
  logic flush_int;
  logic alloc_fire;
  logic wb_fire;

  // full comes from the registered count. An alloc in the same cycle as a
  // commit from a full buffer is therefore still refused.
  assign full_int    = (count == N_CNT);
  assign head_commit = valid[head] & ready[head];
  assign flush_int   = head_commit & mispredict[head];
  // Alloc and writeback are dropped in the flush cycle. The pipeline state
  // they belong to is being squashed.
  assign alloc_fire  = alloc & ~full_int & ~flush_int;
  assign wb_fire     = wbValid & valid[wbROB] & ~flush_int;

  // Outputs are forced low while reset is asserted. This covers the first
  // reset cycle, before the synchronous clear has taken effect.
  assign destROB        = tail;
  assign full           = ~reset & full_int;
  assign validCommit    = ~reset & head_commit;
  assign flush          = ~reset & flush_int;
  assign commitROB      = reset ? '0 : head;
  assign regCommit      = validCommit ? dest[head]   : '0;
  assign commitRegWrite = validCommit & reg_write[head];
  assign commitResult   = validCommit ? result[head] : '0;

  // Control state: occupancy bits, pointers and count
  always_ff @(posedge clk) begin
    if (reset || flush_int) begin
      valid <= '0;
      ready <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wb_fire) ready[wbROB] <= 1'b1;
      if (head_commit) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      // The tail entry is never valid while the buffer is not full. Alloc
      // therefore cannot collide with writeback or commit.
      if (alloc_fire) begin
        valid[tail] <= 1'b1;
        ready[tail] <= 1'b0;
        tail        <= tail + 1'b1;
      end
      case ({alloc_fire, head_commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload: written on alloc/writeback, qualified by valid
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      dest[tail]       <= allocDest;
      branch[tail]     <= allocBranch;
      // Writes to x0 are never committed.
      reg_write[tail]  <= allocRegWrite & (allocDest != '0);
      mispredict[tail] <= 1'b0;
    end
    if (wb_fire) begin
      result[wbROB]     <= wbResult;
      mispredict[wbROB] <= wbMispredict & branch[wbROB];
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc;
  logic [4:0]  allocDest;
  logic        allocRegWrite;
  logic        allocBranch;
  logic [2:0]  destROB;
  logic        full;
  logic        wbValid;
  logic [2:0]  wbROB;
  logic [31:0] wbResult;
  logic        wbMispredict;
  logic        validCommit;
  logic [2:0]  commitROB;
  logic [4:0]  regCommit;
  logic        commitRegWrite;
  logic [31:0] commitResult;
  logic        flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.ROB(2), .REG(4), .WIDTH(31)) dut (
    .clk(clk), .reset(reset),
    .alloc(alloc), .allocDest(allocDest), .allocRegWrite(allocRegWrite),
    .allocBranch(allocBranch), .destROB(destROB), .full(full),
    .wbValid(wbValid), .wbROB(wbROB), .wbResult(wbResult),
    .wbMispredict(wbMispredict), .validCommit(validCommit),
    .commitROB(commitROB), .regCommit(regCommit),
    .commitRegWrite(commitRegWrite), .commitResult(commitResult),
    .flush(flush)
  );

  // Reference model: the live window of instructions in program order
  typedef struct {
    int          rob;
    logic [4:0]  dest;
    bit          rw;
    bit          br;
    bit          rdy;
    bit          mp;
    logic [31:0] res;
  } ent_t;

  ent_t q[$];
  int   mtail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    int   sz;
    bit   vc;
    ent_t h;
    sz = q.size();
    vc = 0;
    h  = '{default: 0};
    if (sz > 0) begin
      h  = q[0];
      vc = !reset && h.rdy;
    end
    chk("m_full",      full,           (!reset && sz == 8));
    chk("m_destROB",   destROB,        mtail);
    chk("m_valid",     validCommit,    vc);
    chk("m_commitROB", commitROB,      reset ? 0 : ((mtail - sz) & 7));
    chk("m_regCommit", regCommit,      vc ? h.dest : 5'd0);
    chk("m_regWrite",  commitRegWrite, vc && h.rw);
    chk("m_result",    commitResult,   vc ? h.res : 32'd0);
    chk("m_flush",     flush,          vc && h.mp);
  endtask

  task automatic model_step();
    bit   was_full;
    bit   vc;
    ent_t e;
    if (reset) begin
      q.delete();
      mtail = 0;
      return;
    end
    vc = (q.size() > 0) && q[0].rdy;
    if (vc && q[0].mp) begin
      q.delete();
      mtail = 0;
      return;
    end
    was_full = (q.size() == 8);
    if (wbValid) begin
      foreach (q[i]) begin
        if (q[i].rob == int'(wbROB)) begin
          e = q[i];
          e.rdy = 1;
          e.res = wbResult;
          e.mp  = wbMispredict && e.br;
          q[i] = e;
        end
      end
    end
    if (vc) void'(q.pop_front());
    if (alloc && !was_full) begin
      e.rob  = mtail;
      e.dest = allocDest;
      e.rw   = allocRegWrite && (allocDest != 0);
      e.br   = allocBranch;
      e.rdy  = 0;
      e.mp   = 0;
      e.res  = 0;
      q.push_back(e);
      mtail = (mtail + 1) % 8;
    end
  endtask

  task automatic tick();
    #1;
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic al(input int d, input bit rw, input bit br);
    alloc = 1; allocDest = 5'(d); allocRegWrite = rw; allocBranch = br;
    tick();
    alloc = 0;
  endtask

  task automatic wb(input int r, input logic [31:0] v, input bit mp);
    wbValid = 1; wbROB = 3'(r); wbResult = v; wbMispredict = mp;
    tick();
    wbValid = 0;
  endtask

  task automatic rst_pulse();
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    reset = 1; alloc = 0; allocDest = 0; allocRegWrite = 0; allocBranch = 0;
    wbValid = 0; wbROB = 0; wbResult = 0; wbMispredict = 0;
    @(posedge clk);
    #1;
    tick();
    reset = 0;
    chk("rst_full", full, 0);
    chk("rst_destROB", destROB, 0);
    chk("rst_valid", validCommit, 0);

    // In-order retirement of out-of-order writebacks
    al(5, 1, 0); al(0, 1, 0); al(7, 0, 0);
    wb(2, 32'h22, 0);
    chk("ord_wait", validCommit, 0);
    wb(0, 32'h11, 0);
    chk("ord_vc0", validCommit, 1);
    chk("ord_rob0", commitROB, 0);
    chk("ord_reg0", regCommit, 5);
    chk("ord_rw0", commitRegWrite, 1);
    chk("ord_res0", commitResult, 32'h11);
    wb(1, 32'h33, 0);
    chk("ord_rob1", commitROB, 1);
    chk("ord_reg1", regCommit, 0);
    chk("ord_rw1", commitRegWrite, 0);
    tick();
    chk("ord_rob2", commitROB, 2);
    chk("ord_reg2", regCommit, 7);
    chk("ord_rw2", commitRegWrite, 0);
    chk("ord_res2", commitResult, 32'h22);
    tick();
    chk("ord_empty", validCommit, 0);

    // Full, rejected alloc, and wrap-around
    rst_pulse();
    for (int i = 0; i < 8; i++) al(i + 1, 1, 0);
    chk("full_set", full, 1);
    chk("full_tail", destROB, 0);
    al(9, 1, 0);
    chk("full_rej", full, 1);
    wb(0, 32'hAA, 0);
    chk("full_vc", validCommit, 1);
    chk("full_still", full, 1);
    alloc = 1; allocDest = 12; allocRegWrite = 1; allocBranch = 0;
    tick();
    chk("full_freed", full, 0);
    chk("full_wrap", destROB, 0);
    tick();
    alloc = 0;
    chk("full_again", full, 1);
    chk("full_tail1", destROB, 1);

    // Mispredicted branch at ROB 2 flushes after committing
    rst_pulse();
    al(1, 1, 0); al(2, 1, 0); al(3, 1, 1); al(4, 1, 0); al(5, 1, 0);
    wb(2, 32'h300, 1);
    wb(0, 32'h100, 0);
    wb(1, 32'h200, 0);
    chk("fl_none", flush, 0);
    tick();
    chk("fl_flush", flush, 1);
    chk("fl_vc", validCommit, 1);
    chk("fl_rob", commitROB, 2);
    chk("fl_reg", regCommit, 3);
    chk("fl_res", commitResult, 32'h300);
    alloc = 1; allocDest = 9; allocRegWrite = 1; allocBranch = 0;
    tick();
    alloc = 0;
    chk("fl_tail", destROB, 0);
    chk("fl_full", full, 0);
    chk("fl_vc0", validCommit, 0);
    wb(3, 32'h5, 0);
    chk("fl_wb3", validCommit, 0);
    al(6, 1, 0);
    wb(0, 32'h66, 1);
    chk("nb_vc", validCommit, 1);
    chk("nb_flush", flush, 0);
    chk("nb_reg", regCommit, 6);
    tick();

    // Reset with five live entries
    rst_pulse();
    for (int i = 0; i < 5; i++) al(i + 10, 1, 0);
    rst_pulse();
    chk("mid_full", full, 0);
    chk("mid_tail", destROB, 0);
    chk("mid_vc", validCommit, 0);
    wb(3, 32'h77, 0);
    chk("mid_wb3", validCommit, 0);
    tick();
    chk("mid_wb3b", validCommit, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset         = ($urandom_range(0, 79) == 0);
      alloc         = ($urandom_range(0, 2) != 0);
      allocDest     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      allocRegWrite = $urandom_range(0, 1);
      allocBranch   = ($urandom_range(0, 3) == 0);
      wbValid       = ($urandom_range(0, 2) != 0);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        wbROB = 3'(q[$urandom_range(0, q.size() - 1)].rob);
      else
        wbROB = 3'($urandom_range(0, 7));
      wbResult      = $urandom;
      wbMispredict  = ($urandom_range(0, 5) == 0);
      tick();
    end
    reset = 0; alloc = 0; wbValid = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
